picomem_arbiter_2_1: RTL and testbench

- Two-master to one-slave arbiter for the PicoMem bus (valid/ready/addr/wdata/wstrb/rdata).
- Lets a second master (DMA / debug loader) share the CPU's downstream bus (SRAM or peripheral mux) with the picorv32.
- Registered grant, round-robin or fixed priority, one transaction per grant.

---
 rtl/picomem_arbiter_2_1.sv | 171 +++++++++++++++++
 tb/tb_picomem_arbiter_2_1.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/picomem_arbiter_2_1.sv
// picomem_arbiter_2_1
//   Two-master / one-slave arbiter for the PicoMem bus. Lets a second master
//   (DMA, debug loader) share the CPU's downstream bus. The grant is held in
//   a registered FSM (IDLE / OWN0 / OWN1). Each grant covers exactly one
//   transaction, and the arbiter always returns to IDLE for one cycle
//   between transfers.
//
//   Optional build macro: PICOMEM_ARB_TIMEOUT_EN
//     When defined, a granted transfer that sees no s_ready for
//     TIMEOUT_CYCLES cycles is force-completed. The owner gets
//     rdata=32'hDEAD_BEEF, and the sticky timeout_flag is set.
//     When undefined, no counter is built and timeout_flag is tied 0.
//
// Parameters
//   ROUND_ROBIN    : 1 = the master not served last wins a tie;
//                    0 = m0 always wins a tie
//   TIMEOUT_CYCLES : force-completion limit, 2..65535 (timeout builds only)
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   m0_* / m1_*           : PicoMem master ports (valid/ready/addr/wdata/wstrb/rdata)
//   s_*                   : PicoMem slave port
//   grant                 : one-hot current owner {OWN1, OWN0}; 00 = idle
//   timeout_flag          : sticky bus-timeout indicator
module picomem_arbiter_2_1 #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       last;       // master served last (0 = m0, 1 = m1)
  logic [1:0] grant_q;
  req_t       m0_req, m1_req, s_req;
  logic       own0, own1, own_valid, tmo_hit, fin, pick1;

  assign own0   = (state == OWN0);
  assign own1   = (state == OWN1);
  assign m0_req = {m0_addr, m0_wdata, m0_wstrb};
  assign m1_req = {m1_addr, m1_wdata, m1_wstrb};

  // Forward the owner's request. IDLE drives all zeros.
  always_comb begin
    s_req     = '0;
    own_valid = 1'b0;
    if (own0) begin
      s_req     = m0_req;
      own_valid = m0_valid;
    end else if (own1) begin
      s_req     = m1_req;
      own_valid = m1_valid;
    end
  end

`ifdef PICOMEM_ARB_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        tflag;

  // A slave ready in the limit cycle wins, so it is a normal completion.
  assign tmo_hit = own_valid && !s_ready && (tcnt == TLIM);

  // IDLE holds the counter at 0. This gives a fresh count on every grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt  <= '0;
      tflag <= 1'b0;
    end else begin
      if (state == IDLE)
        tcnt <= '0;
      else if (!s_ready)
        tcnt <= tcnt + 16'd1;
      if (tmo_hit)
        tflag <= 1'b1;
    end
  end

  assign timeout_flag = tflag;
`else
  logic unused_tlim;
  assign unused_tlim  = ^TLIM;
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // A transfer ends on slave ready or on a forced timeout.
  assign fin = (own0 | own1) & (s_ready | tmo_hit);

  // The slave request is withdrawn in a timeout cycle. The slave must not
  // see a request that the arbiter has already completed.
  assign s_valid = own_valid & ~tmo_hit;
  assign s_addr  = s_req.addr;
  assign s_wdata = s_req.wdata;
  assign s_wstrb = s_req.wstrb;

  assign m0_ready = own0 & (s_ready | tmo_hit);
  assign m1_ready = own1 & (s_ready | tmo_hit);
  assign m0_rdata = !own0 ? 32'h0 : (tmo_hit ? 32'hDEAD_BEEF : s_rdata);
  assign m1_rdata = !own1 ? 32'h0 : (tmo_hit ? 32'hDEAD_BEEF : s_rdata);

  assign grant = grant_q;

  // m1 wins when it is the only requester. On a tie it wins only in
  // round-robin mode, and only when m0 was served last.
  assign pick1 = m1_valid & (~m0_valid | ((ROUND_ROBIN != 0) & ~last));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid | m1_valid) begin
            state   <= pick1 ? OWN1 : OWN0;
            grant_q <= pick1 ? 2'b10 : 2'b01;
          end
        end
        OWN0, OWN1: begin
          if (fin) begin
            state   <= IDLE;
            grant_q <= 2'b00;
            last    <= own1;
          end else if (!own_valid) begin
            // The owner withdrew its request. Release the bus, and leave
            // the round-robin history unchanged.
            state   <= IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picomem_arbiter_2_1.sv
// Directed bench for picomem_arbiter_2_1.
// Two instances share all inputs: u_rr (ROUND_ROBIN=1) and u_fp (ROUND_ROBIN=0).
// Inputs are driven 1 ns after posedge. Outputs are checked 3 ns after posedge.
module tb_picomem_arbiter_2_1;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        rr_m0_ready, rr_m1_ready, rr_s_valid, rr_tflag;
  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
  logic [3:0]  rr_s_wstrb;
  logic [1:0]  rr_grant;

  logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_tflag;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_wstrb;
  logic [1:0]  fp_grant;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  picomem_arbiter_2_1 #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) u_rr (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(rr_m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(rr_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(rr_m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(rr_m1_rdata),
    .s_valid(rr_s_valid), .s_ready(s_ready), .s_addr(rr_s_addr),
    .s_wdata(rr_s_wdata), .s_wstrb(rr_s_wstrb), .s_rdata(s_rdata),
    .grant(rr_grant), .timeout_flag(rr_tflag)
  );

  picomem_arbiter_2_1 #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) u_fp (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(fp_m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(fp_m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_ready(s_ready), .s_addr(fp_s_addr),
    .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb), .s_rdata(s_rdata),
    .grant(fp_grant), .timeout_flag(fp_tflag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_all;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata = '0;
  endtask

  // Expected grants for the tie test, cycles 0..9. m0_valid drops in cycle 7.
  logic [1:0] rr_exp [10] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  logic [1:0] fp_exp [10] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

  initial begin
    int rr_n0, rr_n1, fp_n0, fp_n1, pulses;
    idle_all();
    reset = 1'b1;
    adv(); adv(); settle();

    // ---- reset state
    chk("rst_grant",  32'(rr_grant),    32'h0);
    chk("rst_svalid", 32'(rr_s_valid),  32'h0);
    chk("rst_m0rdy",  32'(rr_m0_ready), 32'h0);
    chk("rst_tflag",  32'(rr_tflag),    32'h0);

    // ---- m0 read alone; slave ready in the 2nd OWN0 cycle
    adv(); reset = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h4000_0010; m0_wstrb = 4'b0000;
    settle();
    chk("rd_lat_svalid", 32'(rr_s_valid), 32'h0);
    adv(); settle();
    chk("rd_svalid", 32'(rr_s_valid), 32'h1);
    chk("rd_grant",  32'(rr_grant),   32'h1);
    chk("rd_saddr",  rr_s_addr,       32'h4000_0010);
    chk("rd_wait_rdy", 32'(rr_m0_ready), 32'h0);
    adv(); s_ready = 1'b1; s_rdata = 32'h1234_5678; settle();
    chk("rd_m0rdy",  32'(rr_m0_ready), 32'h1);
    chk("rd_rdata",  rr_m0_rdata,      32'h1234_5678);
    chk("rd_m1rdy",  32'(rr_m1_ready), 32'h0);
    chk("rd_m1rdata", rr_m1_rdata,     32'h0);
    adv(); idle_all(); settle();
    chk("rd_end_grant",  32'(rr_grant),    32'h0);
    chk("rd_end_m0rdy",  32'(rr_m0_ready), 32'h0);
    chk("rd_end_saddr",  rr_s_addr,        32'h0);

    // ---- m1 write while m0 idle
    adv();
    m1_valid = 1'b1; m1_addr = 32'h8200_0000; m1_wdata = 32'h0000_00A5; m1_wstrb = 4'b0001;
    settle();
    chk("wr_idle_grant", 32'(rr_grant), 32'h0);
    adv(); settle();
    chk("wr_grant",  32'(rr_grant),   32'h2);
    chk("wr_svalid", 32'(rr_s_valid), 32'h1);
    chk("wr_saddr",  rr_s_addr,       32'h8200_0000);
    chk("wr_swdata", rr_s_wdata,      32'h0000_00A5);
    chk("wr_swstrb", 32'(rr_s_wstrb), 32'h1);
    chk("wr_m0rdy",  32'(rr_m0_ready), 32'h0);
    adv(); s_ready = 1'b1; settle();
    chk("wr_m1rdy",  32'(rr_m1_ready), 32'h1);
    chk("wr_m0rdy2", 32'(rr_m0_ready), 32'h0);
    adv(); idle_all(); settle();

    // ---- both masters valid from reset, zero-wait slave
    reset = 1'b1;
    adv();
    reset = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'hCAFE_0000;
    settle();
    chk("tie_idle_rr", 32'(rr_grant), 32'h0);
    chk("tie_idle_fp", 32'(fp_grant), 32'h0);
    rr_n0 = 0; rr_n1 = 0; fp_n0 = 0; fp_n1 = 0;
    for (int i = 0; i < 10; i++) begin
      adv();
      m0_valid = (i != 7);
      settle();
      chk($sformatf("tie_rr_g%0d", i), 32'(rr_grant), 32'(rr_exp[i]));
      chk($sformatf("tie_fp_g%0d", i), 32'(fp_grant), 32'(fp_exp[i]));
      chk($sformatf("tie_rr_sv%0d", i), 32'(rr_s_valid), 32'(rr_exp[i] != 2'b00));
      if (i < 8) begin
        rr_n0 += int'(rr_m0_ready); rr_n1 += int'(rr_m1_ready);
        fp_n0 += int'(fp_m0_ready); fp_n1 += int'(fp_m1_ready);
      end
      if (i == 9) idle_all();
    end
    chk("rr_m0_cnt", 32'(rr_n0), 32'd2);
    chk("rr_m1_cnt", 32'(rr_n1), 32'd2);
    chk("fp_m0_cnt", 32'(fp_n0), 32'd4);
    chk("fp_m1_cnt", 32'(fp_n1), 32'd0);

    // ---- serve m0 so last=0, then reset in the middle of an m1 transfer
    adv(); m0_valid = 1'b1; s_ready = 1'b1; settle();
    chk("idle_srdy_ignored", 32'(rr_m0_ready), 32'h0);
    adv(); settle();
    chk("prime_m0rdy", 32'(rr_m0_ready), 32'h1);
    adv(); m0_valid = 1'b0; s_ready = 1'b0; m1_valid = 1'b1; settle();
    adv(); settle();
    chk("own1_grant", 32'(rr_grant), 32'h2);
    adv(); reset = 1'b1; settle();
    chk("own1_rst_hold", 32'(rr_grant), 32'h2);
    adv(); reset = 1'b0; m0_valid = 1'b1; settle();
    chk("rst_mid_svalid", 32'(rr_s_valid),  32'h0);
    chk("rst_mid_grant",  32'(rr_grant),    32'h0);
    chk("rst_mid_m1rdy",  32'(rr_m1_ready), 32'h0);
    adv(); settle();
    chk("rst_tie_m0", 32'(rr_grant), 32'h1);

    // ---- owner withdraws its request before ready
    m0_valid = 1'b0; settle();
    chk("drop_svalid", 32'(rr_s_valid),  32'h0);
    chk("drop_m0rdy",  32'(rr_m0_ready), 32'h0);
    adv(); m0_valid = 1'b1; settle();
    chk("drop_idle", 32'(rr_grant), 32'h0);
    adv(); settle();
    chk("drop_last_kept", 32'(rr_grant), 32'h1);
    s_ready = 1'b1;
    adv(); m0_valid = 1'b0; s_ready = 1'b0; settle();
    adv(); settle();
    chk("after_m0_m1", 32'(rr_grant), 32'h2);
    s_ready = 1'b1;
    adv(); idle_all(); settle();

`ifdef PICOMEM_ARB_TIMEOUT_EN
    // ---- slave never ready: forced completion in the 8th OWN0 cycle
    adv(); m0_valid = 1'b1; m0_addr = 32'h4000_0020; settle();
    for (int k = 1; k <= 8; k++) begin
      adv(); settle();
      if (k < 8) begin
        chk($sformatf("tmo_wait_rdy%0d", k), 32'(rr_m0_ready), 32'h0);
        chk($sformatf("tmo_wait_sv%0d", k),  32'(rr_s_valid),  32'h1);
      end else begin
        chk("tmo_m0rdy",  32'(rr_m0_ready), 32'h1);
        chk("tmo_rdata",  rr_m0_rdata,      32'hDEAD_BEEF);
        chk("tmo_svalid", 32'(rr_s_valid),  32'h0);
      end
    end
    adv(); m0_valid = 1'b0; m1_valid = 1'b1; settle();
    chk("tmo_flag",  32'(rr_tflag), 32'h1);
    chk("tmo_grant", 32'(rr_grant), 32'h0);
    adv(); s_ready = 1'b1; s_rdata = 32'h0000_0055; settle();
    chk("tmo_m1rdy",  32'(rr_m1_ready), 32'h1);
    chk("tmo_m1data", rr_m1_rdata,      32'h0000_0055);
    adv(); idle_all(); settle();
    chk("tmo_flag_sticky", 32'(rr_tflag), 32'h1);
`else
    // ---- without the timeout a stalled transfer simply waits
    adv(); m0_valid = 1'b1; m0_addr = 32'h4000_0020; settle();
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      adv(); settle();
      pulses += int'(rr_m0_ready);
    end
    chk("stall_no_rdy", 32'(pulses),   32'd0);
    chk("stall_grant",  32'(rr_grant), 32'h1);
    chk("stall_tflag",  32'(rr_tflag), 32'h0);
    s_ready = 1'b1; s_rdata = 32'h0000_0077; settle();
    chk("stall_done",  32'(rr_m0_ready), 32'h1);
    chk("stall_rdata", rr_m0_rdata,      32'h0000_0077);
    adv(); idle_all(); settle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
